rv_main_decoder: RTL and testbench
==================================

Name: rv_main_decoder

Overview:
- Main control decoder for the RV32I single-cycle core.
- Maps the 7-bit opcode to datapath controls: register write, immediate format, ALU operand selects, memory write, result select, branch/jump and ALU-op class.
- Sits beside the ALU decoder in the control unit.
- A sticky illegal-opcode flag is the only sequential state in the default build.

Parameters:
- none.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- op_i  in  7  instruction opcode, instr[6:0]
- reg_write_o  out  1  write rd
- imm_src_o  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- alu_src_o  out  1  ALU B operand: 0 rs2, 1 ImmExt
- mem_write_o  out  1  data-memory write enable
- result_src_o  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 ImmExt
- branch_o  out  1  conditional branch
- jump_o  out  1  unconditional jump (JAL/JALR)
- alu_op_o  out  2  ALU class: 00 add, 01 subtract/compare, 10 use funct3/funct7
- alu_asrc_o  out  1  ALU A operand: 0 rs1, 1 PC
- illegal_o  out  1  op_i is not one of the nine supported opcodes
- illegal_seen_o  out  1  sticky: an illegal opcode has been decoded since reset

Behaviour:
- Decode is purely combinational, zero latency; all outputs change in the same cycle as op_i, independent of clk_i/rst_i.
- Field order per opcode: RW ImmS ASrc MW ResS Br Jp ALUOp AASrc.
  - 0110011 R-type: 1 000 0 0 00 0 0 10 0
  - 0010011 I-ALU: 1 000 1 0 00 0 0 10 0
  - 0000011 Load: 1 000 1 0 01 0 0 00 0
  - 0100011 Store: 0 001 1 1 00 0 0 00 0
  - 1100011 Branch: 0 010 0 0 00 1 0 01 0
  - 1101111 JAL: 1 011 0 0 10 0 1 00 0
  - 1100111 JALR: 1 000 1 0 10 0 1 00 0 (ALU result rs1+imm is the target)
  - 0110111 LUI: 1 100 1 0 11 0 0 00 0
  - 0010111 AUIPC: 1 100 1 0 00 0 0 00 1 (PC+imm)
- Fields that are don't-care for an opcode are driven to 0; no X ever leaves the block.
- Any other opcode, including op_i[1:0] != 11: all controls 0 (NOP-safe: no register or memory write), illegal_o=1.
- illegal_seen_o: reset value 0.
  - Set on the rising clk_i edge where illegal_o=1; holds until rst_i.
  - rst_i and an illegal opcode in the same cycle: reset wins (flag stays 0).
- illegal_o: combinational and unaffected by reset.

Optional Feature:
- Macro MAIN_DECODER_OUTREG_EN.
- Defined: every decoded output including illegal_o is registered on clk_i, giving 1-cycle latency from op_i.
  - rst_i forces all registered outputs to 0 (NOP) on the next edge.
  - illegal_seen_o is set from the registered illegal_o.
- Undefined: combinational decode as above.

Decomposition:
- Package rv_ctrl_pkg: opcode localparams (OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), IMM_* codes, RES_* codes, ALUOP_* codes.
- Single case statement in the top module; no sub-module needed.
- An optional output-register stage rv_ctrl_reg is natural only under MAIN_DECODER_OUTREG_EN.

Test Plan:
- Apply each of the nine opcodes for 10 ns each -> outputs exactly match the table rows, illegal_o=0 (e.g. LUI -> 1 100 1 0 11 0 0 00 0).
- op_i=0000000, then 1111111 -> all controls 0, illegal_o=1; illegal_seen_o=1 after the next clk_i edge and stays 1 after op_i returns to 0110011.
- rst_i=1 for 1 cycle with op_i illegal -> illegal_seen_o=0 after the edge; deassert rst_i -> flag sets on the following edge.
- Walk all 128 opcode values -> illegal_o=1 for exactly 119 values; reg_write_o=0 and mem_write_o=0 whenever illegal_o=1.
- With MAIN_DECODER_OUTREG_EN: apply op_i=0100011 -> mem_write_o=1 one edge later, not before; rst_i mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared control-unit encodings for the RV32I single-cycle core: opcodes,
// immediate/result/ALU-op codes and the decoded control bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       alu_asrc;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/rv_main_decoder.sv
// RV32I main control decoder with sticky illegal-opcode flag.
// Define MAIN_DECODER_OUTREG_EN to register all decoded outputs (1-cycle latency).
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  output logic       reg_write_o,
  output logic [2:0] imm_src_o,
  output logic       alu_src_o,
  output logic       mem_write_o,
  output logic [1:0] result_src_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic [1:0] alu_op_o,
  output logic       alu_asrc_o,
  output logic       illegal_o,
  output logic       illegal_seen_o
);

  ctrl_t dec;
  ctrl_t ctrl;
  logic  seen;

  // Unlisted fields stay 0 from the default so nothing floats for any opcode.
  always_comb begin
    dec = '0;
    case (op_i)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_FUNCT;
      end
      OP_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_FUNCT;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec.imm_src   = IMM_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_src = IMM_B;
        dec.branch  = 1'b1;
        dec.alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_U;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_U;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_ALU;
        dec.alu_op     = ALUOP_ADD;
        dec.alu_asrc   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

`ifdef MAIN_DECODER_OUTREG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) ctrl <= '0;
    else       ctrl <= dec;
  end
`else
  assign ctrl = dec;
`endif

  // Sticky flag follows the visible illegal_o, so it lags one stage in the registered build.
  always_ff @(posedge clk_i) begin
    if (rst_i)             seen <= 1'b0;
    else if (ctrl.illegal) seen <= 1'b1;
  end

  assign reg_write_o    = ctrl.reg_write;
  assign imm_src_o      = ctrl.imm_src;
  assign alu_src_o      = ctrl.alu_src;
  assign mem_write_o    = ctrl.mem_write;
  assign result_src_o   = ctrl.result_src;
  assign branch_o       = ctrl.branch;
  assign jump_o         = ctrl.jump;
  assign alu_op_o       = ctrl.alu_op;
  assign alu_asrc_o     = ctrl.alu_asrc;
  assign illegal_o      = ctrl.illegal;
  assign illegal_seen_o = seen;

endmodule

// File: tb/tb_rv_main_decoder.sv
// Scoreboard bench for rv_main_decoder: stimulus pushes expected vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rv_main_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op  = 7'b0110011;
  logic       reg_write, alu_src, mem_write, branch, jump, alu_asrc, illegal, illegal_seen;
  logic [2:0] imm_src;
  logic [1:0] result_src, alu_op;

  always #5 clk = ~clk;

  rv_main_decoder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .op_i           (op),
    .reg_write_o    (reg_write),
    .imm_src_o      (imm_src),
    .alu_src_o      (alu_src),
    .mem_write_o    (mem_write),
    .result_src_o   (result_src),
    .branch_o       (branch),
    .jump_o         (jump),
    .alu_op_o       (alu_op),
    .alu_asrc_o     (alu_asrc),
    .illegal_o      (illegal),
    .illegal_seen_o (illegal_seen)
  );

  typedef struct {
    logic [13:0] ctrl;
    logic        seen;
    logic        walk;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          walk_illegal = 0;
  logic [13:0] reg_model = '0;
  logic        seen_model = 1'b0;

  // Field order: RW ImmS ASrc MW ResS Br Jp ALUOp AASrc Illegal
  function automatic logic [13:0] golden(input logic [6:0] o);
    case (o)
      7'b0110011: golden = 14'b1_000_0_0_00_0_0_10_0_0;
      7'b0010011: golden = 14'b1_000_1_0_00_0_0_10_0_0;
      7'b0000011: golden = 14'b1_000_1_0_01_0_0_00_0_0;
      7'b0100011: golden = 14'b0_001_1_1_00_0_0_00_0_0;
      7'b1100011: golden = 14'b0_010_0_0_00_1_0_01_0_0;
      7'b1101111: golden = 14'b1_011_0_0_10_0_1_00_0_0;
      7'b1100111: golden = 14'b1_000_1_0_10_0_1_00_0_0;
      7'b0110111: golden = 14'b1_100_1_0_11_0_0_00_0_0;
      7'b0010111: golden = 14'b1_100_1_0_00_0_0_00_1_0;
      default:    golden = 14'b0_000_0_0_00_0_0_00_0_1;
    endcase
  endfunction

  function automatic logic [13:0] visible(input logic [6:0] o);
`ifdef MAIN_DECODER_OUTREG_EN
    visible = reg_model;
`else
    visible = golden(o);
`endif
  endfunction

  // Drive one cycle (inputs settle 1 ns after posedge), queue the expectation, advance models at the edge.
  task automatic step(input logic [6:0] o, input logic r, input logic w, input int tag);
    exp_t e;
    op  = o;
    rst = r;
    e.ctrl = visible(o);
    e.seen = seen_model;
    e.walk = w;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    if (r)                seen_model = 1'b0;
    else if (e.ctrl[0])   seen_model = 1'b1;
    reg_model = r ? 14'd0 : golden(o);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [13:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {reg_write, imm_src, alu_src, mem_write, result_src, branch, jump, alu_op, alu_asrc, illegal};
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl tag=%0d op=%b actual=%b required=%b", e.tag, op, act, e.ctrl);
        end
        checks++;
        if (illegal_seen !== e.seen) begin
          errors++;
          $display("FAIL illegal_seen tag=%0d actual=%b required=%b", e.tag, illegal_seen, e.seen);
        end
        if (illegal === 1'b1) begin
          checks++;
          if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL nop_safe tag=%0d reg_write=%b mem_write=%b required 0 0", e.tag, reg_write, mem_write);
          end
        end
        if (e.walk && illegal === 1'b1) walk_illegal++;
      end
    end
  end

  initial begin : stimulus
    logic [6:0] ops[9];
    int         guard;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    @(posedge clk);
    #1;
    seen_model = 1'b0;
    reg_model  = '0;

    for (int i = 0; i < 9; i++) step(ops[i], 1'b0, 1'b0, 100 + i);

    step(7'b0000000, 1'b0, 1'b0, 200);
    step(7'b1111111, 1'b0, 1'b0, 201);
    step(7'b0110011, 1'b0, 1'b0, 202);
    step(7'b0110011, 1'b0, 1'b0, 203);

    step(7'b0000000, 1'b1, 1'b0, 300);
    step(7'b0000000, 1'b0, 1'b0, 301);
    step(7'b0110011, 1'b0, 1'b0, 302);
    step(7'b0110011, 1'b0, 1'b0, 303);

    step(7'b0100011, 1'b0, 1'b0, 400);
    step(7'b0100011, 1'b1, 1'b0, 401);
    step(7'b0110111, 1'b0, 1'b0, 402);
    step(7'b0110111, 1'b0, 1'b0, 403);

    for (int v = 0; v < 128; v++) step(7'(v), 1'b0, 1'b1, 500 + v);
    step(7'b0110011, 1'b0, 1'b1, 700);
    step(7'b0110011, 1'b0, 1'b0, 701);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    checks++;
    if (walk_illegal != 119) begin
      errors++;
      $display("FAIL illegal_count actual=%0d required=119", walk_illegal);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
